// File: rtl/avalon_pkg.sv
// ---------------------------------------------------------------------------
// avalon_pkg
// Shared definitions for the Avalon-MM memory responder:
//   - fsm_state_t      : command handshake FSM states (IDLE, STALL, GRANT)
//   - DATA_W           : data bus / memory word width
//   - READ_LATENCY_*   : legal range of the read return latency parameter
//   - WAIT_CYCLES_*    : legal range of the waitrequest stall parameter
//   - STALL_CNT_W      : width of the stall counter (covers WAIT_CYCLES_MAX)
// ---------------------------------------------------------------------------
package avalon_pkg;

    localparam int DATA_W           = 32;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 8;
    localparam int WAIT_CYCLES_MIN  = 0;
    localparam int WAIT_CYCLES_MAX  = 15;

    localparam int STALL_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        GRANT
    } fsm_state_t;

endpackage

// File: rtl/rd_latency_pipe.sv
// ---------------------------------------------------------------------------
// rd_latency_pipe
// Fixed-latency return path for read data: a DEPTH-stage shift register of
// {valid, data}. A word entering on in_valid leaves on out_valid exactly
// DEPTH clock edges later. Each data stage only loads when the stage in
// front of it holds a valid word, so out_data keeps the last returned word
// while out_valid is low.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high clear of all stages
//   in_valid  : push a word this edge
//   in_data   : word to push
//   out_valid : one-cycle pulse per returned word
//   out_data  : returned word (held between pulses)
// ---------------------------------------------------------------------------
module rd_latency_pipe
    import avalon_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    // Valid bits always shift; data only moves along with a valid word so the
    // last stage behaves as a hold register for the returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// ---------------------------------------------------------------------------
// avalon_mem_responder
// Avalon-MM slave backed by a DEPTH x 32-bit memory. Commands are stalled
// for WAIT_CYCLES cycles with waitrequest, then accepted. Writes update the
// memory on the acceptance edge; reads sample the memory on the acceptance
// edge and return through a READ_LATENCY-deep pipeline.
// Ports:
//   clk, rst             : clock / asynchronous active-high reset
//   slave_address        : byte address, word index = [log2(DEPTH)+1:2]
//   slave_read/write     : command strobes, held by master while stalled
//   slave_writedata      : write data
//   slave_waitrequest    : command not accepted this cycle
//   slave_readdata       : returned read data (held between returns)
//   slave_readdatavalid  : one-cycle pulse per returned read
//   proto_err            : sticky, read and write seen together
//   rd_count, wr_count   : saturating counts of accepted reads / writes
// ---------------------------------------------------------------------------
module avalon_mem_responder
    import avalon_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,
    output logic              slave_waitrequest,
    output logic [DATA_W-1:0] slave_readdata,
    output logic              slave_readdatavalid,
    output logic              proto_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int ADDR_W         = $clog2(DEPTH);
    localparam int STALL_LOAD_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [STALL_CNT_W-1:0] STALL_LOAD = STALL_LOAD_INT[STALL_CNT_W-1:0];

    fsm_state_t             state;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [DATA_W-1:0]      mem [DEPTH];

    logic              cmd;
    logic              accept;
    logic              wr_accept;
    logic              rd_accept;
    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] rd_word;
    logic              unused_addr_bits;

    assign word_idx         = slave_address[ADDR_W+1:2];
    assign unused_addr_bits = ^{slave_address[31:ADDR_W+2], slave_address[1:0]};

    assign cmd = slave_read | slave_write;

    // Waitrequest must rise in the same cycle the command appears, so it is
    // decoded from the current state and the live command strobes.
    assign slave_waitrequest = (WAIT_CYCLES != 0) &&
                               ((state == STALL) || ((state == IDLE) && cmd));

    // A simultaneous read+write is treated as a write only.
    assign accept    = cmd & ~slave_waitrequest;
    assign wr_accept = accept & slave_write;
    assign rd_accept = accept & slave_read & ~slave_write;

    // Stall FSM: the IDLE cycle that first sees the command is itself one
    // stall cycle, so the counter is loaded with WAIT_CYCLES-1 and STALL
    // hands over to GRANT on the cycle it counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd && (WAIT_CYCLES != 0)) begin
                        stall_cnt <= STALL_LOAD;
                        state     <= (WAIT_CYCLES == 1) ? GRANT : STALL;
                    end
                end
                STALL: begin
                    if (stall_cnt <= 1) begin
                        stall_cnt <= '0;
                        state     <= GRANT;
                    end else begin
                        stall_cnt <= stall_cnt - 1'b1;
                    end
                end
                GRANT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory is deliberately outside the reset domain so its contents
    // survive a reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_idx] <= slave_writedata;
        end
    end

    assign rd_word = mem[word_idx];

    // Status: sticky protocol error and saturating command counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (slave_read && slave_write) begin
                proto_err <= 1'b1;
            end
            if (rd_accept && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_accept && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    rd_latency_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_accept),
        .in_data  (rd_word),
        .out_valid(slave_readdatavalid),
        .out_data (slave_readdata)
    );

endmodule

// File: tb/tb_avalon_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_avalon_mem_responder
// Two responder instances share the clock:
//   dut0 : WAIT_CYCLES=0, READ_LATENCY=2 (pipelining, write/read, proto_err)
//   dut1 : WAIT_CYCLES=5, READ_LATENCY=4 (stall timing, reset mid-read)
// Returned reads are collected on the falling edge together with a cycle
// stamp; a read accepted on the edge that sets cyc to N and returned with
// latency L is seen at the falling edge where cyc == N+L-1.
// ---------------------------------------------------------------------------
module tb_avalon_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_read, a_write, a_wait, a_rdv, a_perr;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [15:0] a_rdc, a_wrc;

    logic        b_rst, b_read, b_write, b_wait, b_rdv, b_perr;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [15:0] b_rdc, b_wrc;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [31:0] a_ret[$];
    logic [31:0] b_ret[$];
    int          a_ret_cyc[$];
    int          b_ret_cyc[$];

    avalon_mem_responder #(.DEPTH(256), .READ_LATENCY(2), .WAIT_CYCLES(0)) dut0 (
        .clk                (clk),
        .rst                (a_rst),
        .slave_address      (a_addr),
        .slave_read         (a_read),
        .slave_write        (a_write),
        .slave_writedata    (a_wdata),
        .slave_waitrequest  (a_wait),
        .slave_readdata     (a_rdata),
        .slave_readdatavalid(a_rdv),
        .proto_err          (a_perr),
        .rd_count           (a_rdc),
        .wr_count           (a_wrc)
    );

    avalon_mem_responder #(.DEPTH(256), .READ_LATENCY(4), .WAIT_CYCLES(5)) dut1 (
        .clk                (clk),
        .rst                (b_rst),
        .slave_address      (b_addr),
        .slave_read         (b_read),
        .slave_write        (b_write),
        .slave_writedata    (b_wdata),
        .slave_waitrequest  (b_wait),
        .slave_readdata     (b_rdata),
        .slave_readdatavalid(b_rdv),
        .proto_err          (b_perr),
        .rd_count           (b_rdc),
        .wr_count           (b_wrc)
    );

    // Free-running cycle stamp.
    always @(posedge clk) cyc <= cyc + 1;

    // Collect every returned read word, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_rdv) begin
            a_ret.push_back(a_rdata);
            a_ret_cyc.push_back(cyc);
        end
        if (b_rdv) begin
            b_ret.push_back(b_rdata);
            b_ret_cyc.push_back(cyc);
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one command on dut0 (sel=0) or dut1 (sel=1), hold it through the
    // stall, and return #1 after the acceptance edge with the command still
    // driven. stalls = number of cycles waitrequest was seen high.
    task automatic applyStimulus(input logic sel, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 output int stalls);
        if (sel) begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = data;
        end else begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = data;
        end
        #1;
        stalls = 0;
        while ((sel ? b_wait : a_wait) && (stalls < 40)) begin
            stalls++;
            @(posedge clk); #1;
        end
        if (stalls >= 40) checkOutput("accept_timeout", stalls, 0);
        @(posedge clk); #1;
    endtask

    task automatic idleBus(input logic sel);
        if (sel) begin
            b_read = 1'b0; b_write = 1'b0;
        end else begin
            a_read = 1'b0; a_write = 1'b0;
        end
    endtask

    initial begin
        int st;
        int acc;

        a_rst = 1'b1; a_read = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
        b_rst = 1'b1; b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;

        // Values held while in reset.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_waitrequest", 32'(a_wait), 0);
        checkOutput("rst_rdv",         32'(a_rdv), 0);
        checkOutput("rst_readdata",    a_rdata, 0);
        checkOutput("rst_proto_err",   32'(a_perr), 0);
        checkOutput("rst_rd_count",    32'(a_rdc), 0);
        checkOutput("rst_wr_count",    32'(a_wrc), 0);
        checkOutput("rst_b_waitreq",   32'(b_wait), 0);
        checkOutput("rst_b_rdv",       32'(b_rdv), 0);

        a_rst = 1'b0;
        b_rst = 1'b0;
        for (int i = 0; i < 4; i++) dut0.mem[i] = 32'(i + 1);
        dut1.mem[2] = 32'hA5A50002;
        @(posedge clk); #1;

        // Four back-to-back reads of words 0..3.
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h0, st);
            if (i == 0) acc = cyc;
            checkOutput($sformatf("b2b_stall%0d", i), st, 0);
        end
        idleBus(1'b0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("b2b_count", a_ret.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < a_ret.size()) checkOutput($sformatf("b2b_data%0d", i), a_ret[i], 32'(i + 1));
        end
        if (a_ret.size() == 4) begin
            checkOutput("b2b_gapless", a_ret_cyc[3] - a_ret_cyc[0], 3);
            checkOutput("b2b_latency", a_ret_cyc[0] + 1 - acc, 2);
        end
        checkOutput("b2b_rd_count", 32'(a_rdc), 4);

        // Write then read the same address.
        a_ret.delete();
        a_ret_cyc.delete();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h11110000, 32'hCEECBEEF, st);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h11110000, 32'h0, st);
        acc = cyc;
        idleBus(1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("wr_rd_count", a_ret.size(), 1);
        if (a_ret.size() == 1) begin
            checkOutput("wr_rd_data",    a_ret[0], 32'hCEECBEEF);
            checkOutput("wr_rd_latency", a_ret_cyc[0] + 1 - acc, 2);
        end
        checkOutput("hold_rdv",      32'(a_rdv), 0);
        checkOutput("hold_readdata", a_rdata, 32'hCEECBEEF);
        checkOutput("wr_rd_wr_cnt",  32'(a_wrc), 1);
        checkOutput("wr_rd_rd_cnt",  32'(a_rdc), 5);

        // Read and write together after a fresh reset.
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        a_ret.delete();
        a_ret_cyc.delete();
        checkOutput("rst2_readdata", a_rdata, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h2222DDD0, 32'h5, st);
        idleBus(1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("perr_flag",     32'(a_perr), 1);
        checkOutput("perr_no_rdv",   a_ret.size(), 0);
        checkOutput("perr_wr_count", 32'(a_wrc), 1);
        checkOutput("perr_rd_count", 32'(a_rdc), 0);
        // Word 0x74 aliased through a different byte address.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h000001D0, 32'h0, st);
        idleBus(1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("perr_readback_cnt", a_ret.size(), 1);
        if (a_ret.size() == 1) checkOutput("perr_readback", a_ret[0], 32'h5);
        checkOutput("perr_sticky", 32'(a_perr), 1);

        // dut1: five waitrequest cycles before acceptance.
        b_ret.delete();
        b_ret_cyc.delete();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h00000008, 32'h0, st);
        acc = cyc;
        idleBus(1'b1);
        #1;
        checkOutput("stall_cycles",   st, 5);
        checkOutput("stall_rd_count", 32'(b_rdc), 1);
        checkOutput("stall_idle_wr",  32'(b_wait), 0);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("stall_ret_cnt", b_ret.size(), 1);
        if (b_ret.size() == 1) begin
            checkOutput("stall_ret_data", b_ret[0], 32'hA5A50002);
            checkOutput("stall_latency",  b_ret_cyc[0] + 1 - acc, 4);
        end

        // dut1: reset one cycle after a read is accepted.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000001C, 32'hDEAD0007, st);
        idleBus(1'b1);
        b_ret.delete();
        b_ret_cyc.delete();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000001C, 32'h0, st);
        idleBus(1'b1);
        @(posedge clk); #1;
        b_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("midrst_no_rdv",   b_ret.size(), 0);
        checkOutput("midrst_rd_count", 32'(b_rdc), 0);
        checkOutput("midrst_wr_count", 32'(b_wrc), 0);
        checkOutput("midrst_readdata", b_rdata, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000001C, 32'h0, st);
        idleBus(1'b1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("midrst_readback_cnt", b_ret.size(), 1);
        if (b_ret.size() == 1) checkOutput("midrst_readback", b_ret[0], 32'hDEAD0007);
        checkOutput("midrst_rd_count2", 32'(b_rdc), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/avalon_mem_responder.md
AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, memory size in 32-bit words; power of two, >= 2.
REQ-002 Parameter READ_LATENCY, default 2, cycles from read acceptance edge to readdatavalid; range 1..8.
REQ-003 Parameter WAIT_CYCLES, default 0, waitrequest stall cycles inserted before each command is accepted; range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 slave_address  input  32  byte address; word index = slave_address[log2(DEPTH)+1:2]; upper bits and [1:0] ignored (aliasing wrap).
REQ-007 slave_read  input  1  read command.
REQ-008 slave_write  input  1  write command.
REQ-009 slave_writedata  input  32  write data.
REQ-010 slave_waitrequest  output  1  command not accepted this cycle; master holds command.
REQ-011 slave_readdata  output  32  read return data, valid only with readdatavalid.
REQ-012 slave_readdatavalid  output  1  one-cycle pulse per returned read word.
REQ-013 proto_err  output  1  sticky flag: read and write asserted in the same cycle.
REQ-014 rd_count, wr_count  output  16 each  accepted reads / writes, saturating at 16'hFFFF.

Function
REQ-015 Command is accepted on a rising edge when (slave_read|slave_write) and slave_waitrequest is 0.
REQ-016 FSM states IDLE, STALL, GRANT; WAIT_CYCLES=0: FSM stays in IDLE and waitrequest is 0 (combinational), commands are accepted every cycle.
REQ-017 WAIT_CYCLES>0: in IDLE with a command pending, waitrequest=1, load stall counter to WAIT_CYCLES-1, go STALL (or GRANT if WAIT_CYCLES=1).
REQ-018 STALL: waitrequest=1, decrement counter, go GRANT when counter reaches 0; total stall cycles = WAIT_CYCLES exactly.
REQ-019 GRANT: waitrequest=0; command accepted this edge; return to IDLE; command withdrawn in GRANT -> return to IDLE, no access, no count.
REQ-020 With no command present, waitrequest=0 in IDLE.
REQ-021 Accepted write: mem[word] <= slave_writedata at the acceptance edge; no response.
REQ-022 Accepted read: mem[word] sampled at acceptance edge, pushed into READ_LATENCY-deep shift pipeline; readdatavalid=1 exactly READ_LATENCY cycles after acceptance edge.
REQ-023 Pipelined reads: up to one read accepted per cycle, returned in order, no bubbles inserted.
REQ-024 Read of address written on an earlier accepted edge returns the new data; read and write never accepted on the same edge.
REQ-025 slave_read & slave_write together: proto_err set, write performed, read dropped (no readdatavalid), only wr_count increments.
REQ-026 slave_readdata holds last returned value when readdatavalid=0.
REQ-027 rd_count / wr_count increment by 1 per accepted command, hold at 16'hFFFF.

Reset
REQ-028 While rst=1: FSM=IDLE, stall counter=0, pipeline valid bits=0, slave_readdatavalid=0, slave_readdata=0, slave_waitrequest=0, proto_err=0, counts=0.
REQ-029 Reset mid-transaction discards all in-flight reads (no readdatavalid after rst deasserts); memory contents are not cleared.
REQ-030 Memory initial content undefined unless loaded by bench via hierarchical init.

Structure
REQ-031 Package avalon_pkg holds the FSM state typedef (IDLE, STALL, GRANT), data width constant 32, and READ_LATENCY/WAIT_CYCLES range limits.
REQ-032 One sub-module rd_latency_pipe (parameter DEPTH=READ_LATENCY; valid+32-bit data shift register, async active-high clear) instantiated once.

Verification
REQ-033 WAIT_CYCLES=0, READ_LATENCY=2: write 32'hCEECBEEF to 32'h11110000, then read same address -> readdatavalid exactly 2 cycles after read acceptance, readdata=32'hCEECBEEF.
REQ-034 WAIT_CYCLES=5: hold read to 32'h00000008 -> waitrequest high exactly 5 cycles, accepted on 6th edge, rd_count=1.
REQ-035 Four back-to-back reads of words 0..3 preloaded 1,2,3,4 -> four consecutive readdatavalid pulses, data 1,2,3,4 in order.
REQ-036 read=write=1 at address 32'h2222DDD0 with data 32'h5 -> proto_err=1, mem word updated to 5, no readdatavalid, wr_count=1, rd_count=0.
REQ-037 Assert rst one cycle after a read is accepted (READ_LATENCY=4) -> readdatavalid never pulses, counts=0, previously written words still readable.
